// File: rtl/gray_conv_arbiter_if.sv
// Request/grant and result handshake bundle shared between requesters, consumer and the
// gray_conv_arbiter. The master side drives requests and out_ready; the slave is the arbiter.
interface gray_conv_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   mode;
    logic [N_REQ*W-1:0] data_in;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [ID_W-1:0]    out_id;
    logic               out_mode;

    modport master (
        output req, mode, data_in, out_ready,
        input  gnt, busy, out_valid, out_data, out_id, out_mode
    );

    modport slave (
        input  req, mode, data_in, out_ready,
        output gnt, busy, out_valid, out_data, out_id, out_mode
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary<->Gray converter: grant one requester, convert its operand in a
// single registered stage, then hold the result under valid/ready until the consumer takes it.
module gray_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_conv_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t           state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [N_REQ-1:0] gnt_q;
    logic             busy_q;
    logic             valid_q;
    logic [W-1:0]     data_q;
    logic [ID_W-1:0]  id_q;
    logic             mode_q;
    logic [W-1:0]     opData_q;
    logic             opMode_q;
    logic [ID_W-1:0]  opId_q;

    logic [W-1:0]     operand [N_REQ];
    logic             found_d;
    logic [ID_W-1:0]  winner_d;
    logic [ID_W-1:0]  idxSel;
    int               idx;
    logic [W-1:0]     selData_d;
    logic             selMode_d;
    logic [W-1:0]     conv_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign operand[i] = bus.data_in[i*W +: W];
    end

    // Search upward from ptr with wrap; the first asserted request wins.
    always_comb begin
        found_d   = 1'b0;
        winner_d  = '0;
        selData_d = '0;
        selMode_d = 1'b0;
        idx       = 0;
        idxSel    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx    = (int'(ptr_q) + k) % N_REQ;
            idxSel = ID_W'(idx);
            if (!found_d && bus.req[idxSel]) begin
                found_d   = 1'b1;
                winner_d  = idxSel;
                selData_d = operand[idxSel];
                selMode_d = bus.mode[idxSel];
            end
        end
    end

    // Gray->binary is a prefix XOR from the MSB down; binary->Gray is a shifted XOR.
    always_comb begin
        conv_d = opData_q ^ (opData_q >> 1);
        if (opMode_q) begin
            conv_d[W-1] = opData_q[W-1];
            for (int i = W - 2; i >= 0; i--) begin
                conv_d[i] = conv_d[i+1] ^ opData_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            id_q     <= '0;
            mode_q   <= 1'b0;
            opData_q <= '0;
            opMode_q <= 1'b0;
            opId_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        opData_q <= selData_d;
                        opMode_q <= selMode_d;
                        opId_q   <= winner_d;
                        gnt_q    <= N_REQ'(1) << winner_d;
                        busy_q   <= 1'b1;
                        ptr_q    <= (int'(winner_d) == N_REQ - 1) ? '0 : winner_d + 1'b1;
                        state_q  <= CONV;
                    end
                end
                CONV: begin
                    gnt_q   <= '0;
                    data_q  <= conv_d;
                    id_q    <= opId_q;
                    mode_q  <= opMode_q;
                    valid_q <= 1'b1;
                    state_q <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.out_mode  = mode_q;

endmodule
